// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared types and encodings for the multi-cycle MIPS controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_EXCEPT   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // Undefined opcodes map to S_EXCEPT; the controller decides whether to honour it.
    function automatic state_e decode_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                          decode_target = S_R_EXEC;
            OP_LW, OP_SW:                      decode_target = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                    decode_target = S_BRANCH;
            OP_J:                              decode_target = S_JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: decode_target = S_I_EXEC;
            default:                           decode_target = S_EXCEPT;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_retire_cnt.sv
// ============================================================================
// mc_retire_cnt : CNT_W-wide enable counter, wraps modulo 2^CNT_W
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_retire_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// mc_control : multi-cycle MIPS main controller (Moore FSM, Mealy mem handshake)
// Optional undefined-opcode trap enabled by macro MC_CONTROL_EXCEPTION_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_control
    import mc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                exception,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instr_count
);

    state_e              state_q;
    state_e              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] op_d;
    logic [5:0]          op_lat;
    state_e              decode_next;
    logic                retire;
    logic [1:0]          alu_op_cls;

    // Later states look only at the opcode latched in DECODE.
    assign op_lat      = 6'(op_q);
    assign decode_next = decode_target(6'(opcode));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        retire        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op_cls    = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        exception     = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                op_d      = opcode;
`ifdef MC_CONTROL_EXCEPTION_EN
                state_d   = decode_next;
`else
                // Without the trap an undefined opcode simply falls back to fetch.
                state_d   = (decode_next == S_EXCEPT) ? S_FETCH : decode_next;
`endif
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_lat == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op_cls = ALU_FUNCT;
                state_d    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op_cls    = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = (op_lat == OP_BNE);
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op_cls = ALU_ITYPE;
                state_d    = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXCEPT: begin
`ifdef MC_CONTROL_EXCEPTION_EN
                exception = 1'b1;
                pc_write  = 1'b1;
                pc_source = PCSRC_EXC;
`endif
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign alu_op = ALUOP_W'(alu_op_cls);
    assign state  = state_q;

    mc_retire_cnt #(
        .CNT_W (CNT_W)
    ) u_retire_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (retire),
        .count_o (instr_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// tb_mc_control : randomized scoreboard bench for mc_control
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_control;

    localparam int CW = 4;
    localparam int NF = 15;
    localparam int F_CYC = 0, F_IRW = 1, F_PCW = 2, F_PCWC = 3, F_BNE = 4,
                   F_REGW = 5, F_RDST = 6, F_M2R = 7, F_MRD = 8, F_MWR = 9,
                   F_IORD = 10, F_EXC = 11, F_ALUOP = 12, F_PCSRC = 13, F_CNT = 14;

    logic          clk;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic          branch_ne, alu_src_a, reg_write, reg_dst, mem_to_reg, exception;
    logic [1:0]    pc_source, alu_op, alu_src_b;
    logic [3:0]    state;
    logic [CW-1:0] instr_count;

    int vectors;
    int miscompares;
    int cnt_model;
    int instr_no;
    int sb[$];
    int acc[NF];
    int prev_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_control #(
        .OPCODE_W (6),
        .ALUOP_W  (2),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .exception     (exception),
        .state         (state),
        .instr_count   (instr_count)
    );

    function automatic string fname(input int i);
        case (i)
            F_CYC:   fname = "cycles";
            F_IRW:   fname = "ir_write_pulses";
            F_PCW:   fname = "pc_write_cycles";
            F_PCWC:  fname = "pc_write_cond_cycles";
            F_BNE:   fname = "branch_ne_cycles";
            F_REGW:  fname = "reg_write_cycles";
            F_RDST:  fname = "reg_dst_at_wb";
            F_M2R:   fname = "mem_to_reg_at_wb";
            F_MRD:   fname = "mem_read_cycles";
            F_MWR:   fname = "mem_write_cycles";
            F_IORD:  fname = "i_or_d_cycles";
            F_EXC:   fname = "exception_cycles";
            F_ALUOP: fname = "exec_alu_op";
            F_PCSRC: fname = "pc_source_set";
            default: fname = "instr_count";
        endcase
    endfunction

    function automatic int outs_vec();
        outs_vec = int'({mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                         branch_ne, reg_write, reg_dst, mem_to_reg, exception,
                         pc_source, alu_op, alu_src_a, alu_src_b, instr_count});
    endfunction

    function automatic bit is_defined(input int op);
        is_defined = (op == 0 || op == 2 || op == 4 || op == 5 || op == 8 || op == 10 ||
                      op == 12 || op == 13 || op == 35 || op == 43);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s (instr %0d, t=%0t): got %0d expected %0d", name, instr_no, $time, got, exp);
        end
    endtask

    task automatic clear_acc();
        for (int i = 0; i < NF; i++) acc[i] = 0;
        acc[F_ALUOP] = -1;
    endtask

    // Model: per-instruction architectural footprint derived from the instruction class.
    task automatic issue(input int op, input int fw, input int ww, input int alt);
        int  e[NF];
        bit  is_mem;
        for (int i = 0; i < NF; i++) e[i] = 0;
        e[F_ALUOP] = -1;
        e[F_IRW]   = 1;
        e[F_PCW]   = 1;
        e[F_MRD]   = fw + 1;
        e[F_PCSRC] = 1;
        is_mem     = (op == 35 || op == 43);
        case (op)
            0: begin e[F_CYC] = fw + 4; e[F_REGW] = 1; e[F_RDST] = 1; e[F_ALUOP] = 2; end
            8, 10, 12, 13: begin e[F_CYC] = fw + 4; e[F_REGW] = 1; e[F_ALUOP] = 3; end
            35: begin
                e[F_CYC] = fw + ww + 5; e[F_REGW] = 1; e[F_M2R] = 1;
                e[F_MRD] = fw + ww + 2; e[F_IORD] = ww + 1; e[F_ALUOP] = 0;
            end
            43: begin
                e[F_CYC] = fw + ww + 4; e[F_MWR] = ww + 1; e[F_IORD] = ww + 1; e[F_ALUOP] = 0;
            end
            4, 5: begin
                e[F_CYC] = fw + 3; e[F_PCWC] = 1; e[F_BNE] = (op == 5) ? 1 : 0;
                e[F_PCSRC] = 3; e[F_ALUOP] = 1;
            end
            2: begin e[F_CYC] = fw + 3; e[F_PCW] = 2; e[F_PCSRC] = 5; end
            default: begin
`ifdef MC_CONTROL_EXCEPTION_EN
                e[F_CYC] = fw + 3; e[F_PCW] = 2; e[F_EXC] = 1; e[F_PCSRC] = 9;
`else
                e[F_CYC] = fw + 2;
`endif
            end
        endcase
        if (is_defined(op)) cnt_model = (cnt_model + 1) % (1 << CW);
        e[F_CNT] = cnt_model;
        for (int i = 0; i < NF; i++) sb.push_back(e[i]);

        for (int k = 0; k < e[F_CYC]; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = (alt >= 0) ? 6'(alt) : 6'($urandom_range(0, 63));
            if (k < fw) mem_ready = 1'b0;
            else if (k == fw) mem_ready = 1'b1;
            if (k == fw + 1) opcode = 6'(op);
            if (is_mem && k >= fw + 3 && k < fw + 3 + ww) mem_ready = 1'b0;
            if (is_mem && k == fw + 3 + ww) mem_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_state", int'(state), 0);
        check("reset_count", int'(instr_count), 0);
        check("reset_outputs", outs_vec(), 0);
        mem_ready = 1'b0;
        opcode    = 6'd0;
        cnt_model = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic abort_in_memrd();
        mem_ready = 1'b1; opcode = 6'd0;
        @(posedge clk); #1;
        opcode = 6'd35; mem_ready = 1'b0;
        @(posedge clk); #1;
        opcode = 6'd0;
        @(posedge clk); #1;
        check("abort_reached_mem_rd", int'(state), 4);
        check("abort_mem_read", int'(mem_read), 1);
        do_reset();
    endtask

    // Monitor: accumulates per-instruction activity, compares on return to FETCH.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            clear_acc();
            prev_state = 0;
        end else begin
            if (state == 4'd0) begin
                check("idle_outputs", outs_vec(), 0);
            end else begin
                if (state == 4'd1 && prev_state != 1 && prev_state != 0) begin
                    acc[F_CNT] = int'(instr_count);
                    if (sb.size() < NF) begin
                        check("unexpected_completion", sb.size(), NF);
                    end else begin
                        for (int i = 0; i < NF; i++) check(fname(i), acc[i], sb.pop_front());
                    end
                    instr_no++;
                    clear_acc();
                end
                acc[F_CYC]++;
                acc[F_IRW]  += int'(ir_write);
                acc[F_PCW]  += int'(pc_write);
                acc[F_PCWC] += int'(pc_write_cond);
                acc[F_BNE]  += int'(branch_ne);
                acc[F_REGW] += int'(reg_write);
                if (reg_write) begin
                    acc[F_RDST] |= int'(reg_dst);
                    acc[F_M2R]  |= int'(mem_to_reg);
                end
                acc[F_MRD]  += int'(mem_read);
                acc[F_MWR]  += int'(mem_write);
                acc[F_IORD] += int'(i_or_d);
                acc[F_EXC]  += int'(exception);
                if (alu_src_a) acc[F_ALUOP] = int'(alu_op);
                if (pc_write || pc_write_cond) acc[F_PCSRC] |= (1 << pc_source);
                check("rd_wr_exclusive", int'(mem_read & mem_write), 0);
            end
            prev_state = int'(state);
        end
    end

    initial begin
        int ops[12];
        int op;
        vectors     = 0;
        miscompares = 0;
        instr_no    = 0;
        cnt_model   = 0;
        prev_state  = 0;
        clear_acc();
        ops = '{0, 35, 43, 4, 5, 2, 8, 10, 12, 13, 63, 0};
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        #2;
        do_reset();

        issue(0, 0, 0, -1);
        issue(35, 2, 3, -1);
        issue(43, 1, 2, -1);
        issue(4, 0, 0, -1);
        issue(5, 0, 0, -1);
        issue(2, 0, 0, -1);
        issue(12, 0, 0, 35);
        issue(63, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 11)];
            if (n % 12 == 11) op = int'($urandom_range(0, 63));
            issue(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

        abort_in_memrd();

        for (int n = 0; n < 17; n++) issue(0, int'($urandom_range(0, 2)), 0, -1);

        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("wrap_count_after_17", int'(instr_count), 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS main controller. Replaces the single-cycle opcode decoder on the multi-cycle datapath.
- Moore FSM sequences fetch, decode, execute, memory and writeback, with Mealy qualification on memory handshakes.
- Drives the shared-memory, IR, PC, ALU-mux and register-file enables.
- Counts retired instructions. Optionally traps undefined opcodes.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, ALU-op width: 00 add/mem, 01 branch-sub, 10 R-funct, 11 I-type.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes current read/write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  address mux: 0 PC, 1 ALUOut.
- ir_write  out  1  IR load.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch).
- branch_ne  out  1  1 selects bne sense (load PC on !zero).
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- alu_op  out  ALUOP_W  ALU control class.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- reg_write  out  1  register file write.
- reg_dst  out  1  0 rt, 1 rd.
- mem_to_reg  out  1  write-back source: 0 ALUOut, 1 MDR.
- exception  out  1  trap taken this cycle.
- state  out  4  current state, for debug.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Async reset:
  - state=IDLE, op_q=0, instr_count=0.
  - All outputs 0 whenever in IDLE.
  - Reset mid-instruction aborts immediately; no partial writeback.
- State encoding: IDLE0 FETCH1 DECODE2 MEM_ADDR3 MEM_RD4 MEM_WB5 MEM_WR6 R_EXEC7 R_WB8 BRANCH9 JUMP10 I_EXEC11 I_WB12 EXCEPT13.
- Any output not listed for a state is 0.
- IDLE: next FETCH unconditionally on first clock after rst_n rises.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Holds in FETCH until mem_ready, then DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - op_q<=opcode.
  - Next state by opcode: 0 goes to R_EXEC; 35 or 43 to MEM_ADDR; 4 or 5 to BRANCH; 2 to JUMP; 8, 10, 12 or 13 to I_EXEC.
  - Any other opcode goes to EXCEPT (feature on) or FETCH (feature off).
- All later states decode op_q, never live opcode.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD if op_q=35, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=1. Next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - branch_ne=(op_q==5).
  - Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Next I_WB.
- I_WB: reg_write=1, reg_dst=0. Next FETCH.
- Retire: instr_count increments by 1 on each clock that leaves MEM_WB, MEM_WR (with mem_ready), R_WB, BRANCH, JUMP or I_WB. It wraps from all-ones to 0.
- Latency:
  - R-type and I-type: 4 cycles.
  - beq, bne, j: 3 cycles.
  - sw: 4 cycles; lw: 5 cycles.
  - Each mem_ready-low cycle adds 1 to these counts.
- mem_read and mem_write are never asserted in the same cycle.

Optional Feature:
- Macro MC_CONTROL_EXCEPTION_EN.
- Defined:
  - Undefined opcode in DECODE goes to EXCEPT.
  - EXCEPT drives exception=1, pc_write=1, pc_source=11 for one cycle, then FETCH.
  - The trap does not increment instr_count.
- Undefined:
  - EXCEPT is unreachable and exception is tied 0.
  - An undefined opcode returns DECODE to FETCH as a NOP with no retire count.

Decomposition:
- Package mc_pkg holds:
  - state enum/localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI;
  - ALU-op class, alu_src_b and pc_source encodings.
- The FSM stays in one module.
- Sub-module mc_retire_cnt (CNT_W-wide enable counter with async active-low reset) is natural and reusable.

Test Plan:
- Reset and R-type:
  - Stimulus: rst_n=0 mid-MEM_RD, release, opcode=0, mem_ready=1.
  - Response: state IDLE→FETCH→DECODE→R_EXEC→R_WB→FETCH.
  - During R_WB: reg_write=1, reg_dst=1. instr_count=1.
- lw with wait states:
  - Stimulus: opcode=35; mem_ready low 2 cycles in FETCH and 3 cycles in MEM_RD.
  - Response: 10 cycles total. ir_write pulses exactly once. MEM_WB has mem_to_reg=1.
- sw:
  - Stimulus: opcode=43.
  - Response: MEM_WR holds mem_write=1, i_or_d=1 until mem_ready. reg_write never 1.
- Branch and jump:
  - Stimulus: beq (4) then bne (5) then j (2).
  - Response: BRANCH shows branch_ne 0 then 1, pc_write_cond=1. JUMP shows pc_source=10. instr_count advances by 3.
- Opcode change after decode:
  - Stimulus: opcode switches 12→35 during I_EXEC.
  - Response: path stays I_EXEC→I_WB, alu_op=11.
- Undefined opcode:
  - Stimulus: opcode=63.
  - Response with macro: EXCEPT with exception=1, pc_source=11 for 1 cycle, then FETCH, no count.
  - Response without macro: DECODE→FETCH, exception stays 0.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 R-type instructions.
  - Response: instr_count=1.
